// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the reset sequencer.
//   STATE_W  width of the state readback port
//   state_t  FSM encodings. The encodings are fixed because software reads
//            them back through the state port. SOFT is always part of the
//            encoding, even in builds where the soft-reset path is absent.
package rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD     = 3'd0,
    ST_PLL_WAIT = 3'd1,
    ST_CLK_SW   = 3'd2,
    ST_CORE_REL = 3'd3,
    ST_USER_REL = 3'd4,
    ST_RUN      = 3'd5,
    ST_SOFT     = 3'd6
  } state_t;

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchroniser with an asynchronous, active-low reset.
//   clock      destination clock
//   resetb     asynchronous active-low reset; loads RESET_VAL into both flops
//   i_d        asynchronous input
//   o_q        synchronised output, two clocks behind i_d
module sync_2ff
  import rst_seq_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic resetb,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on bring-up for the management domain. It runs on the
// external clock and steps through these stages: enable PLL, wait for lock,
// switch the clock mux, release the core reset, then release the user reset.
// Optional build macro: RSTSEQ_SOFT_RESET_EN adds the soft_rst_req port and
// the SOFT state.
// Ports:
//   clock         external (pre-PLL) clock
//   resetb        asynchronous active-low reset (POR and pin combined)
//   pll_lock      PLL lock, asynchronous; synchronised inside
//   soft_rst_req  single-cycle software reset request (macro builds only)
//   pll_ena       PLL enable
//   clk_sel_pll   clock mux select: 1 selects the PLL clock
//   core_resetb   active-low reset to the management core
//   user_resetb   active-low reset to the user project
//   seq_done      high while in RUN
//   lock_timeout  sticky: the PLL never locked, so the chip runs on the external clock
//   lock_lost     sticky: lock dropped while the PLL clock was selected
//   state         current FSM state, for readback
//
// state    | meaning
// ---------+--------------------------------------------------------------
// HOLD     | everything held in reset, waiting for the synchronised release
// PLL_WAIT | PLL enabled; waiting for lock, or for the timeout to expire
// CLK_SW   | clock mux switched (or timed out); waiting one stage gap
// CORE_REL | core reset released; waiting one stage gap
// USER_REL | user reset released; RUN follows on the next cycle
// RUN      | sequence complete; watching for loss of lock
// SOFT     | software reset: both resets asserted for one stage gap
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int STAGE_GAP    = 16
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic               pll_lock,
`ifdef RSTSEQ_SOFT_RESET_EN
  input  logic               soft_rst_req,
`endif
  output logic               pll_ena,
  output logic               clk_sel_pll,
  output logic               core_resetb,
  output logic               user_resetb,
  output logic               seq_done,
  output logic               lock_timeout,
  output logic               lock_lost,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] LOAD_LOCK = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] LOAD_GAP  = CNT_W'(STAGE_GAP);

  logic w_rst_rel;
  logic w_lock_s;
  logic w_expire;
  logic w_lock_fall;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lock_d;
  logic             r_pll_ena;
  logic             r_clk_sel;
  logic             r_core_rb;
  logic             r_user_rb;
  logic             r_seq_done;
  logic             r_lock_to;
  logic             r_lock_lost;

  sync_2ff #(.RESET_VAL(1'b0)) u_rst_sync (
    .clock  (clock),
    .resetb (resetb),
    .i_d    (1'b1),
    .o_q    (w_rst_rel)
  );

  sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
    .clock  (clock),
    .resetb (resetb),
    .i_d    (pll_lock),
    .o_q    (w_lock_s)
  );

  // A count of 1 means the counter reaches 0 on this edge. Acting on that
  // edge keeps the dwell in each timed state exactly equal to the loaded count.
  assign w_expire    = (r_cnt <= CNT_W'(1));
  assign w_lock_fall = r_lock_d & ~w_lock_s;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_lock_d    <= 1'b0;
      r_pll_ena   <= 1'b0;
      r_clk_sel   <= 1'b0;
      r_core_rb   <= 1'b0;
      r_user_rb   <= 1'b0;
      r_seq_done  <= 1'b0;
      r_lock_to   <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_d <= w_lock_s;
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);

      case (r_state)
        ST_HOLD: begin
          if (w_rst_rel) begin
            r_state   <= ST_PLL_WAIT;
            r_pll_ena <= 1'b1;
            r_cnt     <= LOAD_LOCK;
          end
        end
        ST_PLL_WAIT: begin
          // Lock is checked first, so lock arriving in the expiry cycle wins.
          if (w_lock_s) begin
            r_state   <= ST_CLK_SW;
            r_clk_sel <= 1'b1;
            r_cnt     <= LOAD_GAP;
          end else if (w_expire) begin
            r_state   <= ST_CLK_SW;
            r_lock_to <= 1'b1;
            r_cnt     <= LOAD_GAP;
          end
        end
        ST_CLK_SW: begin
          if (w_expire) begin
            r_state   <= ST_CORE_REL;
            r_core_rb <= 1'b1;
            r_cnt     <= LOAD_GAP;
          end
        end
        ST_CORE_REL: begin
          if (w_expire) begin
            r_state   <= ST_USER_REL;
            r_user_rb <= 1'b1;
          end
        end
        ST_USER_REL: begin
          r_state    <= ST_RUN;
          r_seq_done <= 1'b1;
        end
        ST_RUN: begin
          // Fall back to the external clock; there is no automatic re-switch.
          if (w_lock_fall && r_clk_sel) begin
            r_clk_sel   <= 1'b0;
            r_lock_lost <= 1'b1;
          end
`ifdef RSTSEQ_SOFT_RESET_EN
          if (soft_rst_req) begin
            r_state    <= ST_SOFT;
            r_core_rb  <= 1'b0;
            r_user_rb  <= 1'b0;
            r_seq_done <= 1'b0;
            r_cnt      <= LOAD_GAP;
          end
`endif
        end
`ifdef RSTSEQ_SOFT_RESET_EN
        ST_SOFT: begin
          if (w_expire) begin
            r_state   <= ST_CORE_REL;
            r_core_rb <= 1'b1;
            r_cnt     <= LOAD_GAP;
          end
        end
`endif
        default: r_state <= ST_HOLD;
      endcase
    end
  end

  assign pll_ena      = r_pll_ena;
  assign clk_sel_pll  = r_clk_sel;
  assign core_resetb  = r_core_rb;
  assign user_resetb  = r_user_rb;
  assign seq_done     = r_seq_done;
  assign lock_timeout = r_lock_to;
  assign lock_lost    = r_lock_lost;
  assign state        = r_state;

endmodule
